alu: RTL and testbench

Registered 32-bit integer ALU for the datapath execute stage. It takes two operands and a 4-bit opcode and computes add, subtract, bitwise logic, shifts and set-less-than. Result and status flags (zero, carry_out, overflow) are captured in output registers one clock after an accepted request. It has one clock and a synchronous active-low reset.

---
 rtl/alu_if.sv | 36 +++
 rtl/alu.sv | 105 ++++++++++
 tb/tb_alu.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Request/response bundle for the registered 32-bit ALU.
//   in_valid  : request strobe (master -> slave)
//   op1, op2  : operands; op2[4:0] is the shift amount for shifts
//   alu_op    : 4-bit operation select
//   result    : registered 32-bit result (slave -> master)
//   zero      : registered, 1 when result == 0
//   carry_out : registered carry / no-borrow flag (ADD/SUB only)
//   overflow  : registered signed-overflow flag (ADD/SUB only)
//   out_valid : one-cycle pulse when result/flags hold a new value
// The clock and reset are not part of the bundle; they stay plain ports.
// -----------------------------------------------------------------------------
interface alu_if;
   logic        in_valid;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [3:0]  alu_op;
   logic [31:0] result;
   logic        zero;
   logic        carry_out;
   logic        overflow;
   logic        out_valid;

   // Requester side: drives operands, observes results.
   modport master (
      output in_valid, op1, op2, alu_op,
      input  result, zero, carry_out, overflow, out_valid
   );

   // ALU side: consumes operands, drives registered results.
   modport slave (
      input  in_valid, op1, op2, alu_op,
      output result, zero, carry_out, overflow, out_valid
   );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Registered 32-bit integer ALU for the execute stage. The operation is
// computed combinationally from the request and captured in output flops on
// the rising edge where in_valid is high, so results appear one cycle later.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (priority over in_valid)
//   bus   : alu_if.slave bundle (request inputs, registered result outputs)
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT,
//          9 SLTU, 10-15 reserved (result 0).
// -----------------------------------------------------------------------------
module alu (
   input  logic   clk,
   input  logic   rst_n,
   alu_if.slave   bus
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   logic [31:0] result_d,    result_q;
   logic        zero_d,      zero_q;
   logic        carry_d,     carry_q;
   logic        overflow_d,  overflow_q;
   logic        out_valid_q;

   logic [32:0] sum_s;
   logic [4:0]  shamt_s;

   assign shamt_s = bus.op2[4:0];

   // Next result and flags computed from the current request.
   always_comb begin
      result_d   = 32'd0;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      sum_s      = 33'd0;
      case (bus.alu_op)
         OP_ADD: begin
            sum_s      = {1'b0, bus.op1} + {1'b0, bus.op2};
            result_d   = sum_s[31:0];
            carry_d    = sum_s[32];
            // Same-sign operands producing a differently signed sum.
            overflow_d = (bus.op1[31] == bus.op2[31]) && (sum_s[31] != bus.op1[31]);
         end
         OP_SUB: begin
            // Two's-complement subtract; carry = 1 means no borrow.
            sum_s      = {1'b0, bus.op1} + {1'b0, ~bus.op2} + 33'd1;
            result_d   = sum_s[31:0];
            carry_d    = sum_s[32];
            overflow_d = (bus.op1[31] != bus.op2[31]) && (sum_s[31] != bus.op1[31]);
         end
         OP_AND:  result_d = bus.op1 & bus.op2;
         OP_OR:   result_d = bus.op1 | bus.op2;
         OP_XOR:  result_d = bus.op1 ^ bus.op2;
         OP_SLL:  result_d = bus.op1 << shamt_s;
         OP_SRL:  result_d = bus.op1 >> shamt_s;
         OP_SRA:  result_d = $unsigned($signed(bus.op1) >>> shamt_s);
         OP_SLT:  result_d = {31'd0, ($signed(bus.op1) < $signed(bus.op2))};
         OP_SLTU: result_d = {31'd0, (bus.op1 < bus.op2)};
         default: result_d = 32'd0;
      endcase
      zero_d = (result_d == 32'd0);
   end

   // Output registers: reset wins, otherwise capture on accepted request and hold otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q    <= 32'd0;
         zero_q      <= 1'b1;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
         end else begin
            result_q   <= result_q;
            zero_q     <= zero_q;
            carry_q    <= carry_q;
            overflow_q <= overflow_q;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry_out = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Table-driven directed bench for alu: vectors with hand-computed results are
// applied back-to-back, plus hand-written reset, hold and reset-priority
// sequences.
// -----------------------------------------------------------------------------
module tb_alu;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_if bus_if ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] res, input logic z,
                          input logic c, input logic v, input logic ov);
      chk({tag, " result"},    bus_if.result,            res);
      chk({tag, " zero"},      {31'd0, bus_if.zero},      {31'd0, z});
      chk({tag, " carry"},     {31'd0, bus_if.carry_out}, {31'd0, c});
      chk({tag, " overflow"},  {31'd0, bus_if.overflow},  {31'd0, v});
      chk({tag, " out_valid"}, {31'd0, bus_if.out_valid}, {31'd0, ov});
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //          op     a             b             res           z     c     v
      vecs[0]  = {4'h0, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0, 1'b0};
      vecs[1]  = {4'h1, 32'd10,       32'd5,        32'd5,        1'b0, 1'b1, 1'b0};
      vecs[2]  = {4'h2, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[3]  = {4'h3, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0, 1'b0};
      vecs[4]  = {4'h4, 32'd10,       32'd5,        32'd15,       1'b0, 1'b0, 1'b0};
      vecs[5]  = {4'h5, 32'd10,       32'd5,        32'd320,      1'b0, 1'b0, 1'b0};
      vecs[6]  = {4'h6, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[7]  = {4'h7, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[8]  = {4'h8, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[9]  = {4'h9, 32'd10,       32'd5,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[10] = {4'h0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[11] = {4'h0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[12] = {4'h1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[13] = {4'h1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
      vecs[14] = {4'h7, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0};
      vecs[15] = {4'h6, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1'b0};
      vecs[16] = {4'h5, 32'd1,        32'h00000021, 32'd2,        1'b0, 1'b0, 1'b0};
      vecs[17] = {4'h8, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
      vecs[18] = {4'h9, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[19] = {4'h1, 32'd5,        32'd10,       32'hFFFFFFFB, 1'b0, 1'b0, 1'b0};
      vecs[20] = {4'hF, 32'd12345,    32'd1,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[21] = {4'h0, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1, 1'b1};
      vecs[22] = {4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
      vecs[23] = {4'h7, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0, 1'b0};

      // Reset held two cycles while a request is presented: request discarded.
      rst_n           = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.op1      = 32'd3;
      bus_if.op2      = 32'd4;
      bus_if.alu_op   = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Release reset with no request pending.
      @(negedge clk);
      rst_n           = 1'b1;
      bus_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post_reset idle", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Back-to-back table vectors, one per clock.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         bus_if.in_valid = 1'b1;
         bus_if.alu_op   = vecs[i].op;
         bus_if.op1      = vecs[i].a;
         bus_if.op2      = vecs[i].b;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d op%0h", i, vecs[i].op), vecs[i].res,
                 vecs[i].z, vecs[i].c, vecs[i].v, 1'b1);
      end

      // Load a known non-zero value with flags set, then hold for 3 idle cycles
      // while the operand inputs keep changing.
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.alu_op   = 4'h0;
      bus_if.op1      = 32'hFFFFFFFF;
      bus_if.op2      = 32'h80000000;
      @(posedge clk);
      #1;
      chk_all("hold load", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus_if.in_valid = 1'b0;
         bus_if.alu_op   = 4'h2;
         bus_if.op1      = 32'd7 + k;
         bus_if.op2      = 32'd0;
         @(posedge clk);
         #1;
         chk_all($sformatf("hold%0d", k), 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
      end

      // Reset asserted alongside a valid request: reset wins.
      @(negedge clk);
      rst_n           = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.alu_op   = 4'h3;
      bus_if.op1      = 32'hA5A5A5A5;
      bus_if.op2      = 32'd0;
      @(posedge clk);
      #1;
      chk_all("reset priority", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // First edge with rst_n high accepts the pending request.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("first after reset", 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      bus_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("out_valid drop", {31'd0, bus_if.out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
